// File: rtl/swapn_pkg.sv
// swapn_pkg: shared constants, output FSM states and routing helper for swapn
package swapn_pkg;
  localparam int MODE_ROT = 0;
  localparam int MODE_XOR = 1;

  typedef enum logic [1:0] {O_IDLE, O_REQ, O_RTZ} swapn_ostate_t;

  function automatic int swapn_src(input int j, input int s, input int m, input int mode);
    return (mode == MODE_XOR) ? (j ^ s) : ((j + s) % m);
  endfunction
endpackage

// File: rtl/swapn_slot.sv
// swapn_slot: one-token 4-phase capture slot; releases the producer before the token is consumed
module swapn_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_r,
  output logic         o_a,
  input  logic [W-1:0] i_d,
  input  logic         i_consume,
  output logic         o_full,
  output logic [W-1:0] o_d
);
  logic         r_full;
  logic         r_ack;
  logic [W-1:0] r_d;
  logic         w_cap;

  assign w_cap  = i_r & ~r_ack & ~r_full;
  assign o_a    = r_ack;
  assign o_full = r_full;
  assign o_d    = r_d;

  // ack gates capture until the producer returns to zero; full holds off new tokens until consumed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_full <= 1'b0;
      r_ack  <= 1'b0;
      r_d    <= '0;
    end else begin
      r_ack  <= w_cap | (r_ack & i_r);
      r_full <= w_cap | (r_full & ~i_consume);
      r_d    <= w_cap ? i_d : r_d;
    end
endmodule

// File: rtl/swapn.sv
// swapn: M-channel 4-phase permuter; each control token routes one round of inputs to outputs
module swapn
  import swapn_pkg::*;
#(
  parameter int M    = 2,
  parameter int N    = 1,
  parameter int MODE = MODE_XOR,
  localparam int CW  = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   r_i,
  output logic [M-1:0]   a_i,
  input  logic [M*N-1:0] d_i,
  input  logic           rctl_i,
  input  logic [CW-1:0]  dctl_i,
  output logic           actl_i,
  output logic [M-1:0]   r_o,
  input  logic [M-1:0]   a_o,
  output logic [M*N-1:0] d_o
);
  logic [N-1:0]   w_dq [M];
  logic [M-1:0]   w_full;
  logic           w_cfull;
  logic [CW-1:0]  w_s;
  logic           w_idle;
  logic           w_fire;
  swapn_ostate_t  r_st [M];
  swapn_ostate_t  w_nxt [M];
  logic [M*N-1:0] r_do;

  if (M < 2 || (MODE == MODE_XOR && (M & (M - 1)) != 0)) begin : g_bad
    $error("swapn: M must be >= 2, and a power of two for MODE_XOR");
  end

  for (genvar k = 0; k < M; k++) begin : g_slot
    swapn_slot #(.W(N)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_r       (r_i[k]),
      .o_a       (a_i[k]),
      .i_d       (d_i[k*N +: N]),
      .i_consume (w_fire),
      .o_full    (w_full[k]),
      .o_d       (w_dq[k])
    );
  end

  swapn_slot #(.W(CW)) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .i_r       (rctl_i),
    .o_a       (actl_i),
    .i_d       (dctl_i),
    .i_consume (w_fire),
    .o_full    (w_cfull),
    .o_d       (w_s)
  );

  // a round fires once every slot holds a token and every output channel has fully returned to zero
  always_comb begin
    w_idle = 1'b1;
    for (int j = 0; j < M; j++) w_idle = w_idle & (r_st[j] == O_IDLE);
    w_fire = (&w_full) & w_cfull & w_idle & ~(|a_o);
  end

  // per-channel output handshake: each channel runs its own 4-phase cycle after a fire
  always_comb begin
    w_nxt = r_st;
    for (int j = 0; j < M; j++)
      w_nxt[j] = (r_st[j] == O_IDLE && w_fire)  ? O_REQ  :
                 (r_st[j] == O_REQ  && a_o[j])  ? O_RTZ  :
                 (r_st[j] == O_RTZ  && !a_o[j]) ? O_IDLE : r_st[j];
  end

  // output FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_st <= '{default: O_IDLE};
    else r_st <= w_nxt;

  // routed data is latched only on a fire edge and otherwise holds through the RTZ
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_do <= '0;
    else if (w_fire)
      for (int j = 0; j < M; j++) r_do[j*N +: N] <= w_dq[CW'(swapn_src(j, int'(w_s), M, MODE))];

  // request is raised only while a channel waits for its consumer's acknowledge
  always_comb begin
    r_o = '0;
    for (int j = 0; j < M; j++) r_o[j] = (r_st[j] == O_REQ);
  end

  assign d_o = r_do;
endmodule
